// File: rtl/rfsoc_dac_playback_ctrl.sv
// rtl/rfsoc_dac_playback_ctrl.sv - multi-channel DAC waveform load/replay controller (optional broadcast load: RFSOC_DAC_BCAST_EN)
module rfsoc_dac_playback_ctrl #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 256,
    parameter int DEPTH  = 1024
) (
    input  logic                     pl_clk,
    input  logic                     rst,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    input  logic                     load_en,
    input  logic                     clr,
    input  logic                     arm,
    input  logic                     trigger,
    input  logic                     stop,
    input  logic                     loop_mode,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
    output logic [NUM_CH-1:0]        m_axis_tvalid,
    input  logic [NUM_CH-1:0]        m_axis_tready,
    output logic                     busy,
    output logic                     play_done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_L    = (AW+1)'(1);
    localparam logic [CW-1:0] SEL_ONES = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ARMED, ST_PLAY} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     len_q [NUM_CH];
    logic [AW:0]     len_d [NUM_CH];
    logic [AW:0]     max_len_q, max_len_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            valid_q, valid_d;
    logic            prime_q, prime_d;
    logic            loop_q, loop_d;
    logic            stop_pend_q, stop_pend_d;
    logic            play_done_q, play_done_d;

    logic [NUM_CH-1:0] wr_en;
    logic [AW-1:0]     rd_addr;
    logic [AW:0]       max_now;
    logic              bcast;
    logic              sel_in_range;
    logic              s_accept;
    logic              m_accept;
    logic              last_beat;
    logic              finish;

`ifdef RFSOC_DAC_BCAST_EN
    assign bcast = (ch_sel == SEL_ONES);
`else
    assign bcast = 1'b0;
`endif
    assign sel_in_range = ({1'b0, ch_sel} < (CW+1)'(NUM_CH));

    // Load-side handshake: ready unless the targeted channel (or any channel, for broadcast) is full
    always_comb begin
        logic any_full;
        logic sel_full;
        any_full = 1'b0;
        sel_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (len_q[i] == DEPTH_L) begin
                any_full = 1'b1;
                if (sel_in_range && ch_sel == CW'(i)) sel_full = 1'b1;
            end
        end
        if (state_q != ST_LOAD || !load_en) s_axis_tready = 1'b0;
        else if (bcast)                     s_axis_tready = !any_full;
        else                                s_axis_tready = !sel_full;
    end

    assign s_accept = s_axis_tvalid && s_axis_tready;

    // Per-channel write strobes and the longest loaded waveform
    always_comb begin
        wr_en   = '0;
        max_now = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s_accept && (bcast || (sel_in_range && ch_sel == CW'(i)))) wr_en[i] = 1'b1;
            if (len_q[i] > max_now) max_now = len_q[i];
        end
    end

    assign m_accept  = valid_q && (&m_axis_tready);
    assign last_beat = ({1'b0, rd_ptr_q} == (max_len_q - ONE_L));

    // Control FSM, length counters and the shared playback pointer
    always_comb begin
        state_d     = state_q;
        max_len_d   = max_len_q;
        rd_ptr_d    = rd_ptr_q;
        valid_d     = valid_q;
        prime_d     = prime_q;
        loop_d      = loop_q;
        stop_pend_d = stop_pend_q;
        play_done_d = 1'b0;
        finish      = 1'b0;
        rd_addr     = rd_ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            len_d[i] = wr_en[i] ? len_q[i] + ONE_L : len_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    state_d = ST_LOAD;
                end else if (clr) begin
                    for (int i = 0; i < NUM_CH; i++) len_d[i] = '0;
                end else if (arm && max_now != '0) begin
                    max_len_d = max_now;
                    state_d   = ST_ARMED;
                end
            end
            ST_LOAD: begin
                if (!load_en) state_d = ST_IDLE;
            end
            ST_ARMED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (trigger) begin
                    state_d     = ST_PLAY;
                    loop_d      = loop_mode;
                    rd_ptr_d    = '0;
                    valid_d     = 1'b0;
                    prime_d     = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
            ST_PLAY: begin
                if (stop) stop_pend_d = 1'b0 | 1'b1;
                if (!valid_q) begin
                    // Fixed two-cycle start: one cycle to issue the read, one to present it
                    if (stop)         finish  = 1'b1;
                    else if (prime_q) valid_d = 1'b1;
                    else              prime_d = 1'b1;
                end else if (m_accept) begin
                    if (stop || stop_pend_q || (last_beat && !loop_q)) finish = 1'b1;
                    else if (last_beat) rd_ptr_d = '0;
                    else                rd_ptr_d = rd_ptr_q + AW'(1);
                    rd_addr = rd_ptr_d;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (finish) begin
            state_d     = ST_IDLE;
            valid_d     = 1'b0;
            prime_d     = 1'b0;
            stop_pend_d = 1'b0;
            rd_ptr_d    = '0;
            rd_addr     = '0;
            play_done_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            max_len_q   <= '0;
            rd_ptr_q    <= '0;
            valid_q     <= 1'b0;
            prime_q     <= 1'b0;
            loop_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            play_done_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) len_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            max_len_q   <= max_len_d;
            rd_ptr_q    <= rd_ptr_d;
            valid_q     <= valid_d;
            prime_q     <= prime_d;
            loop_q      <= loop_d;
            stop_pend_q <= stop_pend_d;
            play_done_q <= play_done_d;
            for (int i = 0; i < NUM_CH; i++) len_q[i] <= len_d[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_word;

        // Simple dual-port buffer: append at this channel's length, read at the shared pointer
        always_ff @(posedge pl_clk) begin
            if (wr_en[g]) mem[len_q[g][AW-1:0]] <= s_axis_tdata;
            rd_word <= mem[rd_addr];
        end

        // Beats past this channel's own length play the idle code
        assign m_axis_tdata[g*DATA_W +: DATA_W] =
            (valid_q && ({1'b0, rd_ptr_q} < len_q[g])) ? rd_word : '0;
    end

    assign m_axis_tvalid = {NUM_CH{valid_q}};
    assign busy          = (state_q != ST_IDLE);
    assign play_done     = play_done_q;

endmodule

// File: tb/tb_rfsoc_dac_playback_ctrl.sv
// tb/tb_rfsoc_dac_playback_ctrl.sv - scoreboard bench for rfsoc_dac_playback_ctrl
module tb_rfsoc_dac_playback_ctrl;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int CW     = 3;
    localparam int W      = NUM_CH * DATA_W;

    logic              pl_clk = 1'b0;
    logic              rst = 1'b1;
    logic [CW-1:0]     ch_sel = '0;
    logic              load_en = 1'b0, clr = 1'b0, arm = 1'b0, trigger = 1'b0, stop = 1'b0, loop_mode = 1'b0;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic [W-1:0]      m_axis_tdata;
    logic [NUM_CH-1:0] m_axis_tvalid;
    logic [NUM_CH-1:0] m_axis_tready = '1;
    logic              busy, play_done;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0]      exp_q[$];
    logic [DATA_W-1:0] ref_mem [NUM_CH][DEPTH];
    int                ref_len [NUM_CH];

    rfsoc_dac_playback_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .pl_clk(pl_clk), .rst(rst), .ch_sel(ch_sel), .load_en(load_en), .clr(clr),
        .arm(arm), .trigger(trigger), .stop(stop), .loop_mode(loop_mode),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .busy(busy), .play_done(play_done)
    );

    always #5 pl_clk = ~pl_clk;

    task automatic tick();
        @(posedge pl_clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int c = 0; c < NUM_CH; c++) ref_len[c] = 0;
    endfunction

    function automatic void model_write(input int ch, input int val);
`ifdef RFSOC_DAC_BCAST_EN
        if (ch == NUM_CH - 1) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ref_mem[c][ref_len[c]] = DATA_W'(val);
                ref_len[c]++;
            end
            return;
        end
`endif
        ref_mem[ch][ref_len[ch]] = DATA_W'(val);
        ref_len[ch]++;
    endfunction

    function automatic logic [W-1:0] exp_beat(input int k);
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (k < ref_len[c]) v[c*DATA_W +: DATA_W] = ref_mem[c][k];
        return v;
    endfunction

    function automatic void push_beats(input int count, input logic lp);
        int m;
        int k;
        m = 0;
        for (int c = 0; c < NUM_CH; c++) if (ref_len[c] > m) m = ref_len[c];
        for (int j = 0; j < count; j++) begin
            k = lp ? (j % m) : j;
            exp_q.push_back(exp_beat(k));
        end
    endfunction

    task automatic load_beats(input int ch, input int n, input int base);
        int guard;
        load_en = 1'b1;
        ch_sel  = CW'(ch);
        for (int k = 0; k < n; k++) begin
            s_axis_tdata  = DATA_W'(base + k);
            s_axis_tvalid = 1'b1;
            #1;
            guard = 0;
            while (!s_axis_tready && guard < 20) begin
                tick();
                guard++;
            end
            n_vec++;
            if (!s_axis_tready) begin
                n_err++;
                $display("FAIL load_ready ch%0d beat%0d: tready=%b required 1", ch, k, s_axis_tready);
            end else begin
                model_write(ch, base + k);
            end
            tick();
        end
        s_axis_tvalid = 1'b0;
        load_en       = 1'b0;
        tick();
    endtask

    task automatic start_play(input logic lp);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL arm_busy: busy=%b required 1", busy); end
        trigger   = 1'b1;
        loop_mode = lp;
        tick();
        trigger   = 1'b0;
        loop_mode = 1'b0;
        n_vec++;
        if (m_axis_tvalid !== '0) begin n_err++; $display("FAIL latency_t1: tvalid=%h required 0", m_axis_tvalid); end
        tick();
        n_vec++;
        if (m_axis_tvalid !== '0) begin n_err++; $display("FAIL latency_t2: tvalid=%h required 0", m_axis_tvalid); end
        tick();
    endtask

    task automatic run_play(input int stall_at);
        int guard;
        int popped;
        int stall_left;
        guard = 0; popped = 0; stall_left = 3;
        while (exp_q.size() > 0 && guard < 300) begin
            m_axis_tready = '1;
            if (popped == stall_at && stall_left > 0) begin
                m_axis_tready[5] = 1'b0;
                stall_left--;
            end
            #1;
            n_vec++;
            if (m_axis_tvalid !== {NUM_CH{1'b1}}) begin
                n_err++;
                $display("FAIL play_valid beat%0d: tvalid=%h required all ones", popped, m_axis_tvalid);
                exp_q.delete();
            end else if (m_axis_tdata !== exp_q[0]) begin
                n_err++;
                $display("FAIL play_data beat%0d: tdata=%h required %h", popped, m_axis_tdata, exp_q[0]);
                exp_q.delete();
            end else if (m_axis_tready == '1) begin
                void'(exp_q.pop_front());
                popped++;
            end
            tick();
            guard++;
        end
        m_axis_tready = '1;
        if (guard >= 300) begin n_err++; n_vec++; $display("FAIL play_timeout: queue=%0d required 0", exp_q.size()); end
        if (stall_at >= 0) begin
            n_vec++;
            if (stall_left != 0) begin n_err++; $display("FAIL stall_applied: left=%0d required 0", stall_left); end
        end
    endtask

    task automatic check_done(input string name);
        n_vec++;
        if (play_done !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== '0 || m_axis_tdata !== '0) begin
            n_err++;
            $display("FAIL %s_end: done=%b busy=%b tvalid=%h tdata=%h required 1 0 0 0",
                     name, play_done, busy, m_axis_tvalid, m_axis_tdata);
        end
        tick();
        n_vec++;
        if (play_done !== 1'b0) begin n_err++; $display("FAIL %s_pulse: done=%b required 0", name, play_done); end
    endtask

    task automatic test_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
        n_vec++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== '0 || m_axis_tdata !== '0 || busy !== 1'b0 || play_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: tready=%b tvalid=%h tdata=%h busy=%b done=%b required all 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tdata, busy, play_done);
        end
    endtask

    task automatic test_idle_ignores();
        arm = 1'b1; tick(); arm = 1'b0; tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL arm_empty: busy=%b required 0", busy); end
        trigger = 1'b1; tick(); trigger = 1'b0; tick();
        n_vec++;
        if (busy !== 1'b0 || m_axis_tvalid !== '0) begin
            n_err++; $display("FAIL trigger_idle: busy=%b tvalid=%h required 0 0", busy, m_axis_tvalid);
        end
    endtask

    task automatic test_one_shot(input int stall_at, input string name);
        clr = 1'b1; tick(); clr = 1'b0;
        model_clear();
        load_beats(0, 4, 'hA0);
        load_beats(3, 2, 'hB0);
        push_beats(4, 1'b0);
        start_play(1'b0);
        run_play(stall_at);
        check_done(name);
    endtask

    task automatic test_full_loop();
        clr = 1'b1; tick(); clr = 1'b0;
        model_clear();
        arm = 1'b1; tick(); arm = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL clr_arm: busy=%b required 0", busy); end
        load_beats(1, DEPTH, 'h100);
        load_en = 1'b1; ch_sel = CW'(1); s_axis_tdata = 'hDEAD; s_axis_tvalid = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL full_ready: tready=%b required 0", s_axis_tready); end
            tick();
        end
        load_en = 1'b0; s_axis_tvalid = 1'b0;
        tick();
        push_beats(DEPTH + 3, 1'b1);
        start_play(1'b1);
        run_play(-1);
        stop = 1'b1; tick(); stop = 1'b0;
        check_done("loop_stop");
    endtask

    task automatic test_reset_in_play();
        clr = 1'b1; tick(); clr = 1'b0;
        model_clear();
        load_beats(2, 2, 'hC0);
        push_beats(5, 1'b1);
        start_play(1'b1);
        run_play(-1);
        #1 rst = 1'b1;
        tick();
        n_vec++;
        if (m_axis_tvalid !== '0 || busy !== 1'b0 || m_axis_tdata !== '0) begin
            n_err++; $display("FAIL reset_play: tvalid=%h busy=%b tdata=%h required 0 0 0", m_axis_tvalid, busy, m_axis_tdata);
        end
        rst = 1'b0;
        model_clear();
        tick();
        arm = 1'b1; tick(); arm = 1'b0; tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_lengths: busy=%b required 0", busy); end
    endtask

`ifdef RFSOC_DAC_BCAST_EN
    task automatic test_bcast();
        clr = 1'b1; tick(); clr = 1'b0;
        model_clear();
        load_beats(2, 1, 'hC0);
        load_beats(NUM_CH - 1, 3, 'hD0);
        push_beats(4, 1'b0);
        start_play(1'b0);
        run_play(-1);
        check_done("bcast");
    endtask
`endif

    initial begin
        test_reset();
        test_idle_ignores();
        test_one_shot(-1, "one_shot");
        test_one_shot(2, "stall");
        test_full_loop();
        test_reset_in_play();
`ifdef RFSOC_DAC_BCAST_EN
        test_bcast();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end
endmodule
